// File: rtl/countdown_control.sv
// countdown_control: BCD hh:mm:ss countdown timer driven by a 1 Hz tick enable.
//
// Optional feature: define COUNTDOWN_WARN_EN to build the low-time warning
// (warn high while busy and remaining <= 00:00:10); otherwise warn is tied low.
//
// Ports:
//   clkout    in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle request to load duration and begin counting
//   duration  in   24-bit packed BCD hh:mm:ss
//   pause     in   level; holds the count while running
//   abort     in   one-cycle cancel, returns to idle
//   tick      in   one-cycle 1 Hz enable
//   remaining out  current BCD time left
//   busy      out  high while running or paused
//   done      out  one-cycle pulse on natural expiry
//   err       out  one-cycle pulse when start carries an invalid duration
//   warn      out  low-time warning
module countdown_control #(
    parameter logic [7:0] HOUR_MAX = 8'h99
) (
    input  logic        clkout,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] duration,
    input  logic        pause,
    input  logic        abort,
    input  logic        tick,
    output logic [23:0] remaining,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        warn
);

    localparam int unsigned TW = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] remaining_nxt;
    logic          busy_nxt, done_nxt, err_nxt;

    // Legal BCD duration: decimal digits, mm/ss up to 59, hours up to HOUR_MAX.
    function automatic logic dur_valid(input logic [TW-1:0] d);
        logic ok;
        ok = 1'b1;
        if (d[3:0]   > 4'd9) ok = 1'b0;
        if (d[7:4]   > 4'd9) ok = 1'b0;
        if (d[11:8]  > 4'd9) ok = 1'b0;
        if (d[15:12] > 4'd9) ok = 1'b0;
        if (d[19:16] > 4'd9) ok = 1'b0;
        if (d[23:20] > 4'd9) ok = 1'b0;
        if (d[7:0]   > 8'h59) ok = 1'b0;
        if (d[15:8]  > 8'h59) ok = 1'b0;
        if (d[23:16] > HOUR_MAX) ok = 1'b0;
        return ok;
    endfunction

    // Subtract one second from a nonzero BCD hh:mm:ss, borrowing digit by digit.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [3:0] su, st, mu, mt, hu, ht;
        logic       borrow;
        {ht, hu, mt, mu, st, su} = t;
        borrow = 1'b1;
        if (su != 4'd0) begin su = su - 4'd1; borrow = 1'b0; end
        else su = 4'd9;
        if (borrow) begin
            if (st != 4'd0) begin st = st - 4'd1; borrow = 1'b0; end
            else st = 4'd5;
        end
        if (borrow) begin
            if (mu != 4'd0) begin mu = mu - 4'd1; borrow = 1'b0; end
            else mu = 4'd9;
        end
        if (borrow) begin
            if (mt != 4'd0) begin mt = mt - 4'd1; borrow = 1'b0; end
            else mt = 4'd5;
        end
        if (borrow) begin
            if (hu != 4'd0) begin hu = hu - 4'd1; borrow = 1'b0; end
            else hu = 4'd9;
        end
        if (borrow) ht = ht - 4'd1;
        return {ht, hu, mt, mu, st, su};
    endfunction

    // State and output registers
    always_ff @(posedge clkout or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // Next state and next register values; abort overrides everything
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        if (abort) begin
            state_nxt     = S_IDLE;
            remaining_nxt = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (!dur_valid(duration)) begin
                            err_nxt = 1'b1;
                        end else if (duration == '0) begin
                            remaining_nxt = '0;
                            done_nxt      = 1'b1;
                            state_nxt     = S_DONE;
                        end else begin
                            remaining_nxt = duration;
                            state_nxt     = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_nxt = S_PAUSE;
                    end else if (tick) begin
                        if (remaining == TW'(1)) begin
                            remaining_nxt = '0;
                            done_nxt      = 1'b1;
                            state_nxt     = S_DONE;
                        end else begin
                            remaining_nxt = bcd_dec(remaining);
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) state_nxt = S_RUN;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
    end

`ifdef COUNTDOWN_WARN_EN
    logic warn_nxt;

    // BCD ordering matches numeric ordering, so a plain compare suffices
    always_comb begin
        warn_nxt = busy_nxt && (remaining_nxt <= TW'(16));
    end

    always_ff @(posedge clkout or negedge rst) begin
        if (!rst) warn <= 1'b0;
        else      warn <= warn_nxt;
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_control.sv
// Self-checking bench for countdown_control: directed scenarios plus a
// randomized run compared against a seconds-based reference model.
module tb_countdown_control;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;
`ifdef COUNTDOWN_WARN_EN
    localparam logic WARN_ON = 1'b1;
`else
    localparam logic WARN_ON = 1'b0;
`endif

    logic        clkout = 1'b0;
    logic        rst, start, pause, abort, tick;
    logic [23:0] duration;
    logic [23:0] remaining;
    logic        busy, done, err, warn;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time left held as plain seconds
    int   m_st;
    int   m_rem;
    logic m_done, m_err;

    countdown_control dut (
        .clkout    (clkout),
        .rst       (rst),
        .start     (start),
        .duration  (duration),
        .pause     (pause),
        .abort     (abort),
        .tick      (tick),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .warn      (warn)
    );

    always #5 clkout = ~clkout;

    function automatic int two_digits(input logic [7:0] b);
        return 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic dur_ok(input logic [23:0] d);
        logic [23:0] v;
        v = d;
        for (int i = 0; i < 6; i++) begin
            if (int'(v[3:0]) > 9) return 1'b0;
            v = v >> 4;
        end
        return (two_digits(d[15:8]) <= 59) && (two_digits(d[7:0]) <= 59)
            && (two_digits(d[23:16]) <= 99);
    endfunction

    function automatic int to_secs(input logic [23:0] d);
        return two_digits(d[23:16]) * 3600 + two_digits(d[15:8]) * 60 + two_digits(d[7:0]);
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic exp_busy();
        return (m_st == M_RUN) || (m_st == M_PAUSE);
    endfunction

    function automatic logic exp_warn();
        return WARN_ON && exp_busy() && (m_rem <= 10);
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_rem = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [23:0] d, input logic p,
                              input logic a, input logic t);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (a) begin
            m_st = M_IDLE; m_rem = 0;
        end else if (m_st == M_IDLE || m_st == M_DONE) begin
            if (s) begin
                if (!dur_ok(d))          m_err = 1'b1;
                else if (to_secs(d) == 0) begin m_done = 1'b1; m_st = M_DONE; m_rem = 0; end
                else                     begin m_rem = to_secs(d); m_st = M_RUN; end
            end
        end else if (m_st == M_RUN) begin
            if (p) m_st = M_PAUSE;
            else if (t) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_done = 1'b1; m_st = M_DONE; end
            end
        end else begin
            if (!p) m_st = M_RUN;
        end
    endtask

    // Drive one cycle of inputs, step the model, return just after the edge
    task automatic cycle(input logic s, input logic [23:0] d, input logic p,
                         input logic a, input logic t);
        @(negedge clkout);
        start = s; duration = d; pause = p; abort = a; tick = t;
        @(posedge clkout);
        model_step(s, d, p, a, t);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clkout);
        rst = 1'b0; start = 1'b0; duration = '0; pause = 1'b0; abort = 1'b0; tick = 1'b0;
        model_reset();
        @(negedge clkout);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; duration = '0; pause = 1'b0; abort = 1'b0; tick = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({remaining, busy, done, err, warn} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h required 0", {remaining, busy, done, err, warn});
        end
        @(negedge clkout);
        rst = 1'b1;
        cycle(1'b1, 24'h000020, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy} !== {24'h000019, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_prerun: got %h/%b required 000019/1", remaining, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({remaining, busy, done, err, warn} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_async_midrun: got %h required 0", {remaining, busy, done, err, warn});
        end
        @(negedge clkout);
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy, done} !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h/%b/%b required 0/0/0", remaining, busy, done);
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 24'h000003, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({remaining, busy, done} !== {24'h000003, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_load: got %h/%b/%b required 000003/1/0", remaining, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if ({remaining, busy, done} !== {24'(2 - i), i != 2, i == 2}) begin
                n_fail++;
                $display("FAIL basic_tick%0d: got %h/%b/%b required %h/%b/%b", i, remaining,
                         busy, done, 24'(2 - i), i != 2, i == 2);
            end
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy, done, err} !== 27'h0) begin
            n_fail++;
            $display("FAIL basic_done_hold: got %h/%b/%b/%b required 0", remaining, busy, done, err);
        end
    endtask

    task automatic test_hour_borrow();
        cycle(1'b1, 24'h010000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy} !== {24'h005959, 1'b1}) begin
            n_fail++;
            $display("FAIL hour_borrow: got %h/%b required 005959/1", remaining, busy);
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({remaining, busy, done} !== 26'h0) begin
            n_fail++;
            $display("FAIL hour_abort: got %h/%b/%b required 0/0/0", remaining, busy, done);
        end
    endtask

    task automatic test_invalid();
        logic [23:0] bad [5];
        bad[0] = 24'h000070; bad[1] = 24'h00005A; bad[2] = 24'h006000;
        bad[3] = 24'h00A000; bad[4] = 24'h9A0000;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, bad[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({remaining, busy, done, err} !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL invalid_%h: got %h/%b/%b/%b required 0/0/0/1", bad[i],
                         remaining, busy, done, err);
            end
            cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_err_width: got %b required 0", err);
            end
        end
        cycle(1'b1, 24'h000005, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 24'h000070, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({remaining, busy, err} !== {24'h000005, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL start_while_run: got %h/%b/%b required 000005/1/0", remaining, busy, err);
        end
    endtask

    task automatic test_pause();
        cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy} !== {24'h000005, 1'b1}) begin
            n_fail++;
            $display("FAIL pause_beats_tick: got %h/%b required 000005/1", remaining, busy);
        end
        cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy} !== {24'h000005, 1'b1}) begin
            n_fail++;
            $display("FAIL pause_hold: got %h/%b required 000005/1", remaining, busy);
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({remaining, busy} !== {24'h000004, 1'b1}) begin
            n_fail++;
            $display("FAIL pause_resume: got %h/%b required 000004/1", remaining, busy);
        end
    endtask

    task automatic test_abort();
        cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 24'h000012, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({remaining, busy, done} !== 26'h0) begin
            n_fail++;
            $display("FAIL abort_beats_tick: got %h/%b/%b required 0/0/0", remaining, busy, done);
        end
        cycle(1'b1, 24'h000005, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({remaining, busy, err} !== 26'h0) begin
            n_fail++;
            $display("FAIL abort_beats_start: got %h/%b/%b required 0/0/0", remaining, busy, err);
        end
        cycle(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({remaining, busy, done, err} !== {24'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_start: got %h/%b/%b/%b required 0/0/1/0", remaining, busy, done, err);
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_start_pulse: got %b required 0", done);
        end
    endtask

    task automatic test_warn();
        cycle(1'b1, 24'h000011, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (warn !== 1'b0) begin
            n_fail++;
            $display("FAIL warn_at_11: got %b required 0", warn);
        end
        for (int k = 1; k <= 11; k++) begin
            cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if ({remaining, done, warn} !== {to_bcd(11 - k), k == 11, WARN_ON && (k < 11)}) begin
                n_fail++;
                $display("FAIL warn_tick%0d: got %h/%b/%b required %h/%b/%b", k, remaining, done,
                         warn, to_bcd(11 - k), k == 11, WARN_ON && (k < 11));
            end
        end
        cycle(1'b1, 24'h000011, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({remaining, busy, done, err, warn} !== 28'h0) begin
            n_fail++;
            $display("FAIL warn_reset: got %h required 0", {remaining, busy, done, err, warn});
        end
        @(negedge clkout);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic        s, p, a, t;
        logic [23:0] d;
        logic [27:0] expv;
        int          errs;
        errs = 0;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom % 6) == 0;
            case ($urandom % 4)
                0, 1: d = to_bcd(int'($urandom_range(0, 25)));
                2:    d = to_bcd(int'($urandom_range(3590, 3610)));
                default: d = 24'($urandom);
            endcase
            p = ($urandom % 6) == 0;
            a = ($urandom % 50) == 0;
            t = ($urandom % 3) != 0;
            cycle(s, d, p, a, t);
            expv = {to_bcd(m_rem), exp_busy(), m_done, m_err, exp_warn()};
            n_checks++;
            if ({remaining, busy, done, err, warn} !== expv) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got rem=%h busy=%b done=%b err=%b warn=%b required %h",
                             n, remaining, busy, done, err, warn, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hour_borrow();
        test_invalid();
        test_pause();
        test_abort();
        test_warn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
